shift_sub_divider: RTL and testbench

Sequential restoring divider: 16-bit dividend by 8-bit divisor, producing 8-bit quotient and 16-bit remainder in one shift-subtract step per clock. Sits directly upstream of the division result checker. It drives the checker's Quotient, Remainder, RegDivisorOut and DoneFlag inputs, and also reports overflow and divide-by-zero itself.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 14 +
 rtl/shift_sub_divider.sv | 108 ++++++++++
 tb/tb_shift_sub_divider.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state type for the shift/subtract divider.
package div_pkg;
    localparam int DEF_DIVIDEND_W = 16;
    localparam int DEF_DIVISOR_W  = 8;
    localparam int ITER_N         = 9;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: subtract the divisor if it fits and report the quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int W = DEF_DIVIDEND_W
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] div,
    output logic [W-1:0] rem_next,
    output logic         qbit
);
    assign qbit     = (rem >= div);
    assign rem_next = qbit ? (rem - div) : rem;
endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: one compare-subtract per clock, 9-bit quotient saturated to 8 bits.
// Optional macro DIV_ZERO_ABORT_EN finishes a zero-divisor request after a single BUSY cycle.
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [DIVIDEND_W-1:0] Dividend,
    input  logic [DIVISOR_W-1:0]  Divisor,
    output logic                  Busy,
    output logic                  DoneFlag,
    output logic [DIVISOR_W-1:0]  Quotient,
    output logic [DIVIDEND_W-1:0] Remainder,
    output logic [DIVIDEND_W-1:0] RegDivisorOut,
    output logic                  Overflow,
    output logic                  DivZero
);
    state_t                state;
    state_t                next_state;
    logic [DIVIDEND_W-1:0] rem_reg;
    logic [DIVIDEND_W-1:0] div_reg;
    logic [DIVIDEND_W-1:0] rem_next;
    logic [DIVISOR_W-1:0]  q_reg;
    logic [DIVISOR_W:0]    q_final;
    logic [CNT_W-1:0]      k;
    logic                  qbit;
    logic                  accept;
    logic                  last_step;
    logic                  zero_abort;
    logic                  ovf_final;

    div_step #(.W(DIVIDEND_W)) u_step (
        .rem      (rem_reg),
        .div      (div_reg),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // A zero divisor register stays zero for the whole operation, so it doubles as the zero flag.
`ifdef DIV_ZERO_ABORT_EN
    assign zero_abort = (state == BUSY) && (div_reg == '0);
`else
    assign zero_abort = 1'b0;
`endif

    assign accept    = Start && (state != BUSY);
    assign last_step = (state == BUSY) && ((k == '0) || zero_abort);
    assign q_final   = {q_reg, qbit};
    assign ovf_final = q_final[DIVISOR_W] || zero_abort;

    assign Busy          = (state == BUSY);
    assign DoneFlag      = (state == DONE);
    assign Remainder     = rem_reg;
    assign RegDivisorOut = div_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (Start) next_state = BUSY;
            BUSY:       if (last_step) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // q_reg keeps only the low 8 quotient bits seen so far; bit 8 is recovered from q_final on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg  <= '0;
            div_reg  <= '0;
            q_reg    <= '0;
            k        <= '0;
            Quotient <= '0;
            Overflow <= 1'b0;
            DivZero  <= 1'b0;
        end else if (accept) begin
            rem_reg <= Dividend;
            div_reg <= {Divisor, {DIVISOR_W{1'b0}}};
            q_reg   <= '0;
            k       <= CNT_W'(ITER_N - 1);
        end else if (state == BUSY) begin
            if (!zero_abort) begin
                rem_reg <= rem_next;
                q_reg   <= q_final[DIVISOR_W-1:0];
                if (k != '0) begin
                    div_reg <= div_reg >> 1;
                    k       <= k - CNT_W'(1);
                end
            end
            if (last_step) begin
                Overflow <= ovf_final;
                Quotient <= ovf_final ? {DIVISOR_W{1'b1}} : q_final[DIVISOR_W-1:0];
                DivZero  <= (div_reg == '0);
            end
        end
    end
endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: expectations queued at Start, checked on each DoneFlag rise.
module tb_shift_sub_divider;
    logic        clk;
    logic        rst;
    logic        Start;
    logic [15:0] Dividend;
    logic [7:0]  Divisor;
    logic        Busy;
    logic        DoneFlag;
    logic [7:0]  Quotient;
    logic [15:0] Remainder;
    logic [15:0] RegDivisorOut;
    logic        Overflow;
    logic        DivZero;

    typedef struct {
        logic [7:0]  quot;
        logic [15:0] rem;
        logic        check_rem;
        logic        ovf;
        logic        dz;
        logic [15:0] regdiv;
        int          accept_edge;
        int          latency;
    } exp_t;

    exp_t       sb[$];
    int         tests_run  = 0;
    int         fail_count = 0;
    int         edge_count = 0;
    logic       prev_done  = 1'b0;
    logic [7:0] last_quot  = 8'h00;

    shift_sub_divider dut (
        .clk           (clk),
        .rst           (rst),
        .Start         (Start),
        .Dividend      (Dividend),
        .Divisor       (Divisor),
        .Busy          (Busy),
        .DoneFlag      (DoneFlag),
        .Quotient      (Quotient),
        .Remainder     (Remainder),
        .RegDivisorOut (RegDivisorOut),
        .Overflow      (Overflow),
        .DivZero       (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t        e;
        int unsigned q;
        e.quot        = 8'hFF;
        e.rem         = dvd;
        e.check_rem   = 1'b1;
        e.ovf         = 1'b1;
        e.dz          = 1'b0;
        e.regdiv      = {8'h00, dvs};
        e.accept_edge = 0;
        e.latency     = 9;
        if (dvs == 8'h00) begin
            e.dz = 1'b1;
`ifdef DIV_ZERO_ABORT_EN
            e.latency = 1;
`endif
        end else begin
            q = 32'(dvd) / 32'(dvs);
            if (q > 255) begin
                // Overflow remainder is the raw register; only the hand-derived case is checked.
                e.check_rem = (dvd == 16'h1000) && (dvs == 8'h02);
                e.rem       = 16'h0C02;
            end else begin
                e.ovf  = 1'b0;
                e.quot = 8'(q);
                e.rem  = 16'(32'(dvd) % 32'(dvs));
            end
        end
        return e;
    endfunction

    // Called at a falling edge; the following rising edge is the accept edge.
    task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs);
        exp_t e;
        e             = model(dvd, dvs);
        e.accept_edge = edge_count + 1;
        sb.push_back(e);
        Dividend = dvd;
        Divisor  = dvs;
        Start    = 1'b1;
        @(negedge clk);
        Start    = 1'b0;
        Dividend = 16'($urandom);
        Divisor  = 8'($urandom);
    endtask

    task automatic pokeStart(input logic [15:0] dvd, input logic [7:0] dvs);
        Dividend = dvd;
        Divisor  = dvs;
        Start    = 1'b1;
        @(negedge clk);
        Start    = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checkOutput("done_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, Busy, 0);
        checkOutput({tag, "_done"}, DoneFlag, 0);
        checkOutput({tag, "_quot"}, Quotient, 0);
        checkOutput({tag, "_rem"}, Remainder, 0);
        checkOutput({tag, "_regdiv"}, RegDivisorOut, 0);
        checkOutput({tag, "_ovf"}, Overflow, 0);
        checkOutput({tag, "_dz"}, DivZero, 0);
    endtask

    // Result monitor, sampled 1 ns after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_count++;
            if (Busy && DoneFlag) checkOutput("busy_done_excl", 1, 0);
            if (DoneFlag && !prev_done) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("quotient", Quotient, e.quot);
                    if (e.check_rem) checkOutput("remainder", Remainder, e.rem);
                    checkOutput("overflow", Overflow, e.ovf);
                    checkOutput("divzero", DivZero, e.dz);
                    checkOutput("regdivisor", RegDivisorOut, e.regdiv);
                    checkOutput("latency", 32'(edge_count - e.accept_edge), 32'(e.latency));
                    last_quot = e.quot;
                end
            end
            prev_done = DoneFlag;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  rdvs;
        logic [15:0] rdvd;
        rst      = 1'b1;
        Start    = 1'b0;
        Dividend = 16'h0000;
        Divisor  = 8'h00;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'h03E8, 8'h07);
        waitDone();
        @(negedge clk);
        applyStimulus(16'hFEFF, 8'hFF);
        waitDone();
        @(negedge clk);
        applyStimulus(16'h1000, 8'h02);
        waitDone();
        @(negedge clk);
        applyStimulus(16'h1234, 8'h00);
        waitDone();

        // Start during BUSY cycle 4 must be ignored.
        @(negedge clk);
        applyStimulus(16'h00C8, 8'h09);
        repeat (3) @(negedge clk);
        checkOutput("busy_mid", Busy, 1);
        checkOutput("quot_hold", Quotient, last_quot);
        pokeStart(16'hFFFF, 8'h01);
        waitDone();

        // Start in the first DONE cycle is accepted immediately.
        @(negedge clk);
        applyStimulus(16'h0100, 8'h10);
        for (int i = 0; i < 40 && !DoneFlag; i++) @(negedge clk);
        checkOutput("b2b_done_seen", DoneFlag, 1);
        applyStimulus(16'h0064, 8'h0A);
        checkOutput("b2b_done_drop", DoneFlag, 0);
        checkOutput("b2b_busy", Busy, 1);
        waitDone();

        // Reset in BUSY cycle 5 aborts the operation.
        @(negedge clk);
        pokeStart(16'h5555, 8'h33);
        repeat (4) @(negedge clk);
        checkOutput("rst_pre_busy", Busy, 1);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midrst");
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(16'h0010, 8'h03);
        waitDone();

        for (int i = 0; i < 5; i++) begin
            rdvs = 8'($urandom_range(1, 255));
            rdvd = {8'($urandom_range(0, 32'(rdvs) - 1)), 8'($urandom_range(0, 255))};
            @(negedge clk);
            applyStimulus(rdvd, rdvs);
            waitDone();
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end
endmodule
